// File: rtl/tpu_host_seq.sv
// Host-side sequencer for a 16-element TPU: loads A/W operand bytes, pulses start,
// waits for compute, then streams the 16 result bytes out. Define TPU_SEQ_TIMEOUT_EN for a busy timeout.
module tpu_host_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_in,
  output logic [3:0]        wr_addr,
  output logic [3:0]        rd_addr,
  output logic [1:0]        mem_acc,
  output logic              dv_a,
  output logic              dv_w,
  output logic              start,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  input  logic              out_ready,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_A    = 2'b01;
  localparam logic [1:0] ACC_W    = 2'b10;
  localparam logic [1:0] ACC_RD   = 2'b11;
  localparam logic [3:0] IDX_LAST = 4'd15;

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_W, START, WAIT, RD_REQ, RD_CAP, OUT
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        accept;
  logic        rd_req;
  logic        done_set;
  logic        wait_first_p1;
  logic [1:0]  wr_acc_p1;

`ifdef TPU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;
  logic [7:0] tcnt;
  logic       err_set;
  logic       err_clr;
  logic       err_r;
`endif

  assign accept  = in_ready & in_valid;
  assign mem_acc = rd_req ? ACC_RD : wr_acc_p1;
  assign rd_addr = rd_req ? idx : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    start     = 1'b0;
    rd_req    = 1'b0;
    done_set  = 1'b0;
`ifdef TPU_SEQ_TIMEOUT_EN
    err_set   = 1'b0;
    err_clr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = LOAD_A;
          idx_nxt   = 4'd0;
`ifdef TPU_SEQ_TIMEOUT_EN
          err_clr   = 1'b1;
`endif
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_nxt = idx + 4'd1;
          if (idx == IDX_LAST) state_nxt = LOAD_W;
        end
      end
      LOAD_W: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_nxt = idx + 4'd1;
          if (idx == IDX_LAST) state_nxt = START;
        end
      end
      START: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // busy may lag start by a cycle, so the first WAIT cycle never exits
        if (!wait_first_p1) begin
          if (!busy) begin
            state_nxt = RD_REQ;
            idx_nxt   = 4'd0;
          end
`ifdef TPU_SEQ_TIMEOUT_EN
          else if (tcnt == TIMEOUT_LAST) begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
            err_set   = 1'b1;
          end
`endif
        end
      end
      RD_REQ: begin
        rd_req    = 1'b1;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (idx == IDX_LAST) begin
            idx_nxt   = 4'd0;
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = RD_REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered TPU write port and result holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_a          <= 1'b0;
      dv_w          <= 1'b0;
      wr_acc_p1     <= ACC_NONE;
      data_in       <= '0;
      wr_addr       <= 4'd0;
      wait_first_p1 <= 1'b0;
      done          <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_idx       <= 4'd0;
    end else begin
      dv_a          <= accept && (state == LOAD_A);
      dv_w          <= accept && (state == LOAD_W);
      wait_first_p1 <= (state == START);
      done          <= done_set;
      if (accept) begin
        data_in   <= in_data;
        wr_addr   <= idx;
        wr_acc_p1 <= (state == LOAD_A) ? ACC_A : ACC_W;
      end else begin
        wr_acc_p1 <= ACC_NONE;
      end
      if (state == RD_CAP) begin
        out_valid <= 1'b1;
        out_data  <= data_out;
        out_idx   <= idx;
      end else if ((state == OUT) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef TPU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= 8'd0;
      err_r <= 1'b0;
    end else begin
      tcnt <= (state == WAIT) ? tcnt + 8'd1 : 8'd0;
      if (err_clr)      err_r <= 1'b0;
      else if (err_set) err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_host_seq.sv
// Self-checking bench for tpu_host_seq with a small TPU model (busy window, A0+addr read data).
module tb_tpu_host_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] data_in;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic [1:0] mem_acc;
  logic       dv_a;
  logic       dv_w;
  logic       start;
  logic       busy;
  logic [7:0] data_out = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_idx;
  logic       out_ready;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tpu_host_seq dut (
    .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .data_in(data_in), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .mem_acc(mem_acc), .dv_a(dv_a), .dv_w(dv_w), .start(start), .busy(busy),
    .data_out(data_out), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready), .done(done), .err(err)
  );

  // TPU model
  int   busy_cnt = 0;
  logic stuck    = 1'b0;
  assign busy = stuck || (busy_cnt != 0);
  always @(posedge clk) begin
    if (start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (mem_acc == 2'b11) data_out <= 8'hA0 + {4'h0, rd_addr};
  end

  // Event monitor, sampled on the falling edge
  logic [3:0] a_addr [512];
  logic [7:0] a_data [512];
  logic [3:0] w_addr [512];
  logic [7:0] w_data [512];
  logic [7:0] r_data [512];
  logic [3:0] r_idx  [512];
  logic [3:0] rd_log [512];
  int a_n = 0, w_n = 0, r_n = 0, rd_n = 0;
  int start_n = 0, done_n = 0, ov_n = 0, acc_bad = 0, consec_a = 0, consec_w = 0;
  logic prev_a = 1'b0, prev_w = 1'b0;

  always @(negedge clk) begin
    if (dv_a && a_n < 512) begin
      a_addr[a_n] <= wr_addr;
      a_data[a_n] <= data_in;
      a_n <= a_n + 1;
      if (mem_acc != 2'b01) acc_bad <= acc_bad + 1;
      if (prev_a) consec_a <= consec_a + 1;
    end
    if (dv_w && w_n < 512) begin
      w_addr[w_n] <= wr_addr;
      w_data[w_n] <= data_in;
      w_n <= w_n + 1;
      if (mem_acc != 2'b10) acc_bad <= acc_bad + 1;
      if (prev_w) consec_w <= consec_w + 1;
    end
    prev_a <= dv_a;
    prev_w <= dv_w;
    if (start) start_n <= start_n + 1;
    if (done) done_n <= done_n + 1;
    if (out_valid) ov_n <= ov_n + 1;
    if (out_valid && out_ready && r_n < 512) begin
      r_data[r_n] <= out_data;
      r_idx[r_n]  <= out_idx;
      r_n <= r_n + 1;
    end
    if (mem_acc == 2'b11 && rd_n < 512) begin
      rd_log[rd_n] <= rd_addr;
      rd_n <= rd_n + 1;
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] w;
    logic [7:0] res;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  0);
    check({tag, "_data_in"},   32'(data_in),   0);
    check({tag, "_wr_addr"},   32'(wr_addr),   0);
    check({tag, "_rd_addr"},   32'(rd_addr),   0);
    check({tag, "_mem_acc"},   32'(mem_acc),   0);
    check({tag, "_dv_a"},      32'(dv_a),      0);
    check({tag, "_dv_w"},      32'(dv_w),      0);
    check({tag, "_start"},     32'(start),     0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"},  32'(out_data),  0);
    check({tag, "_out_idx"},   32'(out_idx),   0);
    check({tag, "_done"},      32'(done),      0);
    check({tag, "_err"},       32'(err),       0);
  endtask

  // Feed operand bytes [first, first+count); index 0..15 are A, 16..31 are W
  task automatic feed(input int first, input int count, input bit gaps);
    for (int k = first; k < first + count; k++) begin
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = (k < 16) ? tbl[k].a : tbl[k-16].w;
      while (!in_ready && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) check($sformatf("feed_ready[%0d]", k), 32'(in_ready), 1);
      step();
      if (gaps) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input bit gaps, input int stall_idx, input int stall_len,
                     input int exp_consec);
    int a0, w0, r0, rd0, s0, d0, ca0, cw0, bad0;
    int n, stall_left;
    a0 = a_n; w0 = w_n; r0 = r_n; rd0 = rd_n; s0 = start_n; d0 = done_n;
    ca0 = consec_a; cw0 = consec_w; bad0 = acc_bad;
    go_pulse();
    feed(0, 32, gaps);
    stall_left = stall_len;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (out_valid && out_idx == 4'(stall_idx) && stall_left > 0) begin
        out_ready = 1'b0;
        check({tag, "_stall_data"}, 32'(out_data), 8'hA0 + stall_idx);
        check({tag, "_stall_no_rd"}, 32'(mem_acc == 2'b11), 0);
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      step();
      n++;
    end
    out_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(done), 1);
    if (stall_len > 0) check({tag, "_stall_taken"}, stall_left, 0);
    @(negedge clk);
    #1;
    check({tag, "_a_count"}, a_n - a0, 16);
    check({tag, "_w_count"}, w_n - w0, 16);
    check({tag, "_r_count"}, r_n - r0, 16);
    check({tag, "_rd_count"}, rd_n - rd0, 16);
    check({tag, "_start_count"}, start_n - s0, 1);
    check({tag, "_done_count"}, done_n - d0, 1);
    check({tag, "_acc_code"}, acc_bad - bad0, 0);
    check({tag, "_consec_a"}, consec_a - ca0, exp_consec);
    check({tag, "_consec_w"}, consec_w - cw0, exp_consec);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_a_addr[%0d]", tag, i), 32'(a_addr[a0+i]), i);
      check($sformatf("%s_a_data[%0d]", tag, i), 32'(a_data[a0+i]), 32'(tbl[i].a));
      check($sformatf("%s_w_addr[%0d]", tag, i), 32'(w_addr[w0+i]), i);
      check($sformatf("%s_w_data[%0d]", tag, i), 32'(w_data[w0+i]), 32'(tbl[i].w));
      check($sformatf("%s_rd_addr[%0d]", tag, i), 32'(rd_log[rd0+i]), i);
      check($sformatf("%s_out_data[%0d]", tag, i), 32'(r_data[r0+i]), 32'(tbl[i].res));
      check($sformatf("%s_out_idx[%0d]", tag, i), 32'(r_idx[r0+i]), i);
    end
  endtask

  initial begin
    int n, d0, ov0, rd0;
    tbl[0]  = '{8'd4, 8'd1, 8'hA0};
    tbl[1]  = '{8'd0, 8'd2, 8'hA1};
    tbl[2]  = '{8'd2, 8'd3, 8'hA2};
    tbl[3]  = '{8'd1, 8'd4, 8'hA3};
    tbl[4]  = '{8'd4, 8'd1, 8'hA4};
    tbl[5]  = '{8'd3, 8'd2, 8'hA5};
    tbl[6]  = '{8'd2, 8'd3, 8'hA6};
    tbl[7]  = '{8'd0, 8'd4, 8'hA7};
    tbl[8]  = '{8'd4, 8'd1, 8'hA8};
    tbl[9]  = '{8'd3, 8'd2, 8'hA9};
    tbl[10] = '{8'd0, 8'd3, 8'hAA};
    tbl[11] = '{8'd1, 8'd4, 8'hAB};
    tbl[12] = '{8'd4, 8'd1, 8'hAC};
    tbl[13] = '{8'd3, 8'd2, 8'hAD};
    tbl[14] = '{8'd2, 8'd3, 8'hAE};
    tbl[15] = '{8'd1, 8'd4, 8'hAF};

    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    repeat (2) step();
    check("idle_no_go_ready", 32'(in_ready), 0);

    run("run1", 1'b0, 0, 0, 15);
    run("run2_stall", 1'b0, 7, 5, 15);
    run("run3_gaps", 1'b1, 0, 0, 0);

    // Reset in LOAD_W with idx=5 and a byte on offer
    go_pulse();
    feed(0, 21, 1'b0);
    check("pre_rst_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = tbl[5].w;
    rst      = 1'b1;
    step();
    check_zero("mid_rst");
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    check("post_rst_idle_ready", 32'(in_ready), 0);
    check("post_rst_idle_acc", 32'(mem_acc), 0);
    run("run4_after_rst", 1'b0, 0, 0, 15);

    // busy stuck high after start
    stuck = 1'b1;
    d0 = done_n; ov0 = ov_n; rd0 = rd_n;
    go_pulse();
    feed(0, 32, 1'b0);
`ifdef TPU_SEQ_TIMEOUT_EN
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("timeout_err", 32'(err), 1);
    check("timeout_cycles", n, 256);
    repeat (3) step();
    check("timeout_err_sticky", 32'(err), 1);
    check("timeout_idle_ready", 32'(in_ready), 0);
    go_pulse();
    check("timeout_err_cleared", 32'(err), 0);
    check("timeout_new_load", 32'(in_ready), 1);
`else
    repeat (400) step();
    check("stuck_err", 32'(err), 0);
    check("stuck_wait_ready", 32'(in_ready), 0);
    check("stuck_wait_acc", 32'(mem_acc), 0);
`endif
    check("stuck_no_out_valid", ov_n - ov0, 0);
    check("stuck_no_done", done_n - d0, 0);
    check("stuck_no_reads", rd_n - rd0, 0);
    stuck = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    run("run5_recover", 1'b0, 0, 0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
